// File: rtl/unison_readout_capture.sv
// unison_readout_capture
// Synchronises the concatenated digital_unison readout lanes into wb_clk_i,
// captures one word per rising edge of clk_master into a FIFO and exposes the
// FIFO to firmware through a Wishbone slave (CTRL, STATUS, DATA, THRESH).
// Build macro UNISON_CAPTURE_TIMESTAMP_EN: when defined, an 8-bit rise counter
// is stamped into bits [31:24] of every captured word; otherwise those bits are 0.
module unison_readout_capture #(
  parameter int          NUM_INST   = 6,
  parameter int          LANE_W     = 4,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_dat_i,
  input  logic [31:0]                  wbs_adr_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  input  logic [NUM_INST*LANE_W-1:0]   read_out_i,
  input  logic                         clk_master_i,
  output logic                         irq_o
);

  localparam int               CAP_W    = NUM_INST * LANE_W;
  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DATA   = 3'd2;
  localparam logic [2:0] REG_THRESH = 3'd3;

  // Synchroniser stages: strobe p0..p2 (p2 only for edge detect), data p0..p1
  logic             cm_p0, cm_p1, cm_p2;
  logic [CAP_W-1:0] rd_p0, rd_p1;
  logic             rise;

  // Bus request captured in the hit cycle, acted upon in the ack cycle
  logic             hit, ack;
  logic [2:0]       req_idx;
  logic             req_we;
  logic [31:0]      req_dat;
  logic [31:0]      rdata;

  // FIFO and control state
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] thr, thr_nxt;
  logic             en, en_nxt, irq_en, irq_en_nxt;
  logic             ovf, ovf_nxt, irq_nxt;
  logic             full, empty;
  logic             wr_acc, rd_acc, ctrl_wr, flush, ovf_clr, thr_wr;
  logic             pop, push_req, push, ovf_set;
  logic [7:0]       ts_field;
  logic [31:0]      push_word;
  logic             unused_ok;

  // Stage p0..p2: strobe synchroniser plus edge-detect flop
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cm_p0 <= 1'b0;
      cm_p1 <= 1'b0;
      cm_p2 <= 1'b0;
    end else begin
      cm_p0 <= clk_master_i;
      cm_p1 <= cm_p0;
      cm_p2 <= cm_p1;
    end
  end

  // Stage p0..p1: lane data synchroniser, aligned with the strobe's p1
  always_ff @(posedge wb_clk_i) begin
    rd_p0 <= read_out_i;
    rd_p1 <= rd_p0;
  end

  assign rise = cm_p1 & ~cm_p2;

  // A 32-byte window is decoded so offsets past THRESH still ack and read 0.
  assign hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADR[31:5]) & ~ack;

  // Single-cycle ack one cycle after the hit; reset drops any pending ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ack <= 1'b0;
    else          ack <= hit;
  end

  // Hold the request so the ack cycle does not depend on the master holding inputs
  always_ff @(posedge wb_clk_i) begin
    if (hit) begin
      req_idx <= wbs_adr_i[4:2];
      req_we  <= wbs_we_i;
      req_dat <= wbs_dat_i;
    end
  end

  assign wr_acc   = ack & req_we;
  assign rd_acc   = ack & ~req_we;
  assign ctrl_wr  = wr_acc & (req_idx == REG_CTRL);
  assign flush    = ctrl_wr & req_dat[1];
  assign ovf_clr  = wr_acc & (req_idx == REG_STATUS) & req_dat[10];
  assign thr_wr   = wr_acc & (req_idx == REG_THRESH);

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // A pop on an empty FIFO is ignored even if a push lands in the same cycle.
  assign pop      = rd_acc & (req_idx == REG_DATA) & ~empty;
  assign push_req = rise & en & ~flush;
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

`ifdef UNISON_CAPTURE_TIMESTAMP_EN
  logic [7:0] ts_cnt;

  // Rise counter: counts every rise regardless of en, cleared by flush
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) ts_cnt <= 8'h00;
    else if (rise)         ts_cnt <= ts_cnt + 8'd1;
  end

  assign ts_field = ts_cnt;
`else
  assign ts_field = 8'h00;
`endif

  // Assemble the captured word: timestamp on top, lanes at the bottom
  always_comb begin
    push_word            = '0;
    push_word[CAP_W-1:0] = rd_p1;
    push_word[31:24]     = ts_field;
  end

  // Next-state of the control registers; irq is registered from these
  always_comb begin
    count_nxt  = count;
    ovf_nxt    = ovf;
    en_nxt     = en;
    irq_en_nxt = irq_en;
    thr_nxt    = thr;
    if (flush)             count_nxt = '0;
    else if (push && !pop) count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
    if (ovf_clr) ovf_nxt = 1'b0;
    if (ovf_set) ovf_nxt = 1'b1;
    if (ctrl_wr) begin
      en_nxt     = req_dat[0];
      irq_en_nxt = req_dat[2];
    end
    if (thr_wr) thr_nxt = req_dat[CNT_W-1:0];
    irq_nxt = irq_en_nxt & (ovf_nxt | ((thr_nxt != '0) & (count_nxt >= thr_nxt)));
  end

  // Control state: pointers, occupancy, sticky overflow, registers, interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      en     <= 1'b0;
      irq_en <= 1'b0;
      thr    <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count  <= count_nxt;
      ovf    <= ovf_nxt;
      en     <= en_nxt;
      irq_en <= irq_en_nxt;
      thr    <= thr_nxt;
      irq_o  <= irq_nxt;
    end
  end

  // FIFO storage write
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // Register read mux, evaluated in the ack cycle
  always_comb begin
    rdata = '0;
    case (req_idx)
      REG_CTRL: begin
        rdata[0] = en;
        rdata[2] = irq_en;
      end
      REG_STATUS: begin
        rdata[CNT_W-1:0] = count;
        rdata[8]         = empty;
        rdata[9]         = full;
        rdata[10]        = ovf;
      end
      REG_DATA:   if (!empty) rdata = mem[rd_ptr];
      REG_THRESH: rdata[CNT_W-1:0] = thr;
      default:    rdata = '0;
    endcase
  end

  assign wbs_ack_o = ack;
  assign wbs_dat_o = rd_acc ? rdata : 32'h0;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], req_dat};

endmodule

// File: tb/tb_unison_readout_capture.sv
// Directed bench for unison_readout_capture: register access, capture,
// FIFO boundaries, threshold/overflow interrupt, flush and reset behaviour.
module tb_unison_readout_capture;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_DATA   = 32'h3000_0008;
  localparam logic [31:0] A_THRESH = 32'h3000_000C;
  localparam logic [31:0] A_UNMAP  = 32'h3000_0010;

`ifdef UNISON_CAPTURE_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic [23:0] read_out;
  logic        cm;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdat;
  logic        irq_at_ack;
  logic [31:0] exp_q[$];
  int          ts_cnt;
  bit          m_en;
  logic [31:0] e;

  unison_readout_capture dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_dat_i    (dat_i),
    .wbs_adr_i    (adr),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_o),
    .read_out_i   (read_out),
    .clk_master_i (cm),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [23:0] d, input int ts);
    logic [7:0] t;
    t = TS_ON ? ts[7:0] : 8'h00;
    return {t, d};
  endfunction

  // One Wishbone access; checks the ack arrives exactly one cycle after the request.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] wd);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got        = 1;
        last_rdat  = dat_o;
        irq_at_ack = irq;
      end else begin
        lat++;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_latency", lat, 1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    wb_xfer(1'b0, a, 32'h0);
    chk(tag, last_rdat, exp);
  endtask

  task automatic model_rise(input logic [23:0] d);
    if (m_en && exp_q.size() < 16) exp_q.push_back(word_of(d, ts_cnt));
    ts_cnt = (ts_cnt + 1) % 256;
  endtask

  task automatic pulse(input logic [23:0] d);
    @(posedge clk); #1;
    read_out = d; cm = 1'b1;
    repeat (4) @(posedge clk);
    #1 cm = 1'b0;
    repeat (4) @(posedge clk);
    model_rise(d);
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] x;
    x = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
    rd_chk(tag, A_DATA, x);
  endtask

  // Raise clk_master so the synchronised rise lands in the ack cycle of the access.
  task automatic xfer_on_rise(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [23:0] d);
    @(posedge clk); #1;
    read_out = d; cm = 1'b1;
    wb_xfer(w, a, wd);
    repeat (2) @(posedge clk);
    #1 cm = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    @(negedge clk);
    chk(tag, {31'h0, irq}, {31'h0, exp});
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
    dat_i = 32'h0; adr = 32'h0; read_out = 24'h0; cm = 1'b0;
    last_rdat = 32'h0; irq_at_ack = 1'b0; ts_cnt = 0; m_en = 0; e = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    rd_chk("rst_status", A_STATUS, 32'h0000_0100);
    rd_chk("rst_ctrl",   A_CTRL,   32'h0);
    rd_chk("rst_thresh", A_THRESH, 32'h0);

    // Basic capture of three identical samples
    wb_xfer(1'b1, A_CTRL, 32'h1); m_en = 1;
    repeat (3) pulse(24'hA5A5A5);
    rd_chk("cap3_status", A_STATUS, 32'h0000_0003);
    chk("cap3_word0", exp_q[0], word_of(24'hA5A5A5, 0));
    pop_chk("cap3_data0");
    pop_chk("cap3_data1");
    pop_chk("cap3_data2");
    rd_chk("cap3_empty", A_STATUS, 32'h0000_0100);

    // Fill to full, then overflow with irq_en set
    wb_xfer(1'b1, A_CTRL, 32'h5);
    for (int i = 0; i < 16; i++) pulse(24'h000100 + 24'(i));
    rd_chk("full_status", A_STATUS, 32'h0000_0210);
    chk_irq("full_no_irq", 1'b0);
    pulse(24'h0001FF);
    rd_chk("ovf_status", A_STATUS, 32'h0000_0610);
    chk_irq("ovf_irq", 1'b1);
    wb_xfer(1'b1, A_STATUS, 32'h0000_0400);
    rd_chk("ovf_cleared", A_STATUS, 32'h0000_0210);
    chk_irq("ovf_irq_clr", 1'b0);
    for (int i = 0; i < 16; i++) pop_chk("drain_ovf");
    rd_chk("drain_ovf_empty", A_STATUS, 32'h0000_0100);

    // Threshold interrupt timing
    wb_xfer(1'b1, A_THRESH, 32'h4);
    rd_chk("thresh_rd", A_THRESH, 32'h4);
    for (int i = 0; i < 3; i++) pulse(24'hC0FFE0 + 24'(i));
    chk_irq("thr_below", 1'b0);
    @(posedge clk); #1;
    read_out = 24'hC0FFE3; cm = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("irq_rise_cycle", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_after_push", {31'h0, irq}, 32'h1);
    @(posedge clk); #1 cm = 1'b0;
    repeat (4) @(posedge clk);
    model_rise(24'hC0FFE3);
    pop_chk("thr_pop");
    chk("irq_at_pop_ack", {31'h0, irq_at_ack}, 32'h1);
    chk("irq_after_pop", {31'h0, irq}, 32'h0);
    rd_chk("thr_status", A_STATUS, 32'h0000_0003);

    // Full FIFO: pop and push in the same cycle
    for (int i = 0; i < 13; i++) pulse(24'h5A0000 + 24'(i));
    rd_chk("refull_status", A_STATUS, 32'h0000_0210);
    e = exp_q.pop_front();
    xfer_on_rise(1'b0, A_DATA, 32'h0, 24'hBEEF01);
    chk("fullpp_oldest", last_rdat, e);
    model_rise(24'hBEEF01);
    rd_chk("fullpp_status", A_STATUS, 32'h0000_0210);
    for (int i = 0; i < 16; i++) pop_chk("drain_fullpp");
    rd_chk("fullpp_empty", A_STATUS, 32'h0000_0100);

    // Flush coincident with a rise
    wb_xfer(1'b1, A_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) pulse(24'h777000 + 24'(i));
    rd_chk("pre_flush_status", A_STATUS, 32'h0000_0005);
    xfer_on_rise(1'b1, A_CTRL, 32'h3, 24'hDEAD00);
    exp_q.delete();
    ts_cnt = 0;
    rd_chk("flush_status", A_STATUS, 32'h0000_0100);
    rd_chk("flush_ctrl", A_CTRL, 32'h1);
    pop_chk("flush_empty_read");
    pulse(24'h123456);
    chk("post_flush_model", exp_q[0], word_of(24'h123456, 0));
    pop_chk("post_flush_word");

    // Empty read and unmapped offset
    rd_chk("empty_read", A_DATA, 32'h0);
    rd_chk("unmapped_read", A_UNMAP, 32'h0);
    wb_xfer(1'b1, A_UNMAP, 32'hFFFF_FFFF);
    rd_chk("unmapped_ctrl", A_CTRL, 32'h1);
    rd_chk("unmapped_thresh", A_THRESH, 32'h4);
    rd_chk("unmapped_status", A_STATUS, 32'h0000_0100);

    // Disabling capture stops pushes
    wb_xfer(1'b1, A_CTRL, 32'h0); m_en = 0;
    pulse(24'h0BAD00);
    rd_chk("en_off_status", A_STATUS, 32'h0000_0100);

    // Reset in the middle of a transaction
    wb_xfer(1'b1, A_CTRL, 32'h5);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_THRESH; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack0", {31'h0, ack}, 32'h0);
    @(negedge clk);
    chk("rst_mid_ack1", {31'h0, ack}, 32'h0);
    chk("rst_mid_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    ts_cnt = 0; exp_q.delete();
    rd_chk("rst_mid_ctrl",   A_CTRL,   32'h0);
    rd_chk("rst_mid_thresh", A_THRESH, 32'h0);
    rd_chk("rst_mid_status", A_STATUS, 32'h0000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
